// File: rtl/seg_scan_drv_pkg.sv
// seg_scan_drv_pkg: shared constants, segment table and helpers for the scan driver
package seg_scan_drv_pkg;
  localparam logic [1:0] DIG_T1 = 2'd0;
  localparam logic [1:0] DIG_U1 = 2'd1;
  localparam logic [1:0] DIG_T2 = 2'd2;
  localparam logic [1:0] DIG_U2 = 2'd3;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] SL_OFF = 4'hF;
  localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  typedef enum logic [1:0] {B2B_IDLE, B2B_SHIFT, B2B_DONE} b2b_state_e;
  // Active-high gfedcba pattern; non-decimal codes light nothing
  function automatic logic [6:0] segtab(input logic [3:0] d);
    return (d < 4'd10) ? SEGTAB[d] : 7'h00;
  endfunction
  // Countdowns above 99 cannot be shown on two digits
  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, 7 shift cycles then one done cycle
module bin2bcd_seq
  import seg_scan_drv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [6:0] bin_i,
  output logic [7:0] bcd_o,
  output logic       done_o
);
  b2b_state_e  state_q, state_d;
  logic [14:0] sh_q, sh_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  // Adjust both BCD nibbles before each shift; load on start, report on done
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    adj     = sh_q;
    if (sh_q[10:7] >= 4'd5) adj[10:7] = sh_q[10:7] + 4'd3;
    if (sh_q[14:11] >= 4'd5) adj[14:11] = sh_q[14:11] + 4'd3;
    case (state_q)
      B2B_IDLE: if (start_i) begin
        sh_d    = {8'd0, bin_i};
        cnt_d   = 3'd0;
        state_d = B2B_SHIFT;
      end
      B2B_SHIFT: begin
        sh_d    = {adj[13:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd6) ? B2B_DONE : B2B_SHIFT;
      end
      default: state_d = B2B_IDLE;
    endcase
  end
  // Converter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= B2B_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bcd_o  = sh_q[14:7];
  assign done_o = (state_q == B2B_DONE);
endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: multiplexes two 0..99 countdowns onto a 4-digit common-anode display
module seg_scan_drv
  import seg_scan_drv_pkg::*;
#(
  parameter int SCAN_DIV = 10000,
  parameter int GUARD    = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] Cnt1,
  input  logic [6:0] Cnt2,
  input  logic       Blank,
  output logic [7:0] Seg,
  output logic [3:0] Sl
);
  localparam int PW = $clog2(SCAN_DIV);
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    snap1_q, snap2_q;
  logic          start_q;
  logic [7:0]    conv1_q, conv2_q, disp1_q, disp2_q, bcd1, bcd2, sel;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    sl_q, sl_d, dig;
  logic          done1, done2, tick, capture, commit, dark;
  assign tick    = (presc_q == PW'(SCAN_DIV - 1));
  assign capture = tick && (idx_q == DIG_T2);
  assign commit  = tick && (idx_q == DIG_U2);
  // Slot prescaler and digit index advance together on tick
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
  end
  // Scan position register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      presc_q <= '0;
      idx_q   <= DIG_T1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end
  bin2bcd_seq u_b2b1 (.clk(Clk), .rst_n(Reset), .start_i(start_q), .bin_i(snap1_q), .bcd_o(bcd1), .done_o(done1));
  bin2bcd_seq u_b2b2 (.clk(Clk), .rst_n(Reset), .start_i(start_q), .bin_i(snap2_q), .bcd_o(bcd2), .done_o(done2));
  // Snapshot in slot 2, convert during slot 3, commit at frame wrap so a frame never tears
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      snap1_q <= '0;
      snap2_q <= '0;
      start_q <= 1'b0;
      conv1_q <= '0;
      conv2_q <= '0;
      disp1_q <= '0;
      disp2_q <= '0;
    end else begin
      start_q <= capture;
      if (capture) begin
        snap1_q <= sat99(Cnt1);
        snap2_q <= sat99(Cnt2);
      end
      if (done1) conv1_q <= bcd1;
      if (done2) conv2_q <= bcd2;
      if (commit) begin
        disp1_q <= conv1_q;
        disp2_q <= conv2_q;
      end
    end
  end
  // Pick the digit for the current slot; go dark in the guard window or when blanked
  always_comb begin
    sel   = idx_q[1] ? disp2_q : disp1_q;
    dig   = idx_q[0] ? sel[3:0] : sel[7:4];
    dark  = Blank || (presc_q < PW'(GUARD));
    sl_d  = dark ? SL_OFF : ~(4'b0001 << idx_q);
    seg_d = (dark || (BLANK_LZ && !idx_q[0] && dig == 4'd0)) ? SEG_OFF : ~{1'b0, segtab(dig)};
  end
  // Registered pin drivers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      seg_q <= SEG_OFF;
      sl_q  <= SL_OFF;
    end else begin
      seg_q <= seg_d;
      sl_q  <= sl_d;
    end
  end
  assign Seg = seg_q;
  assign Sl  = sl_q;
endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: scoreboard bench against a frame-level display model
module tb_seg_scan_drv;
  logic       Clk = 1'b0, Reset = 1'b0, Blank = 1'b0;
  logic [6:0] Cnt1 = '0, Cnt2 = '0;
  logic [7:0] seg_a, seg_b;
  logic [3:0] sl_a, sl_b;
  typedef struct {logic [7:0] seg_lz; logic [7:0] seg_nz; logic [3:0] sl;} exp_t;
  exp_t q[$];
  int checks = 0, passed = 0;
  int s = 0, d1 = 0, d2 = 0, c1 = 0, c2 = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #50 Clk = ~Clk;

  seg_scan_drv #(.SCAN_DIV(16), .GUARD(2), .BLANK_LZ(1'b1)) dut_lz (
    .Clk(Clk), .Reset(Reset), .Cnt1(Cnt1), .Cnt2(Cnt2), .Blank(Blank), .Seg(seg_a), .Sl(sl_a));
  seg_scan_drv #(.SCAN_DIV(16), .GUARD(2), .BLANK_LZ(1'b0)) dut_nz (
    .Clk(Clk), .Reset(Reset), .Cnt1(Cnt1), .Cnt2(Cnt2), .Blank(Blank), .Seg(seg_b), .Sl(sl_b));

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got seg/sl %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [7:0] exp_seg(input int v, input int idx, input bit lz);
    int digit;
    digit = (idx % 2 == 1) ? v % 10 : v / 10;
    if (idx % 2 == 0 && digit == 0 && lz) return 8'hFF;
    return ~{1'b0, seg_tab[digit]};
  endfunction

  // Reference model: s counts clock edges since reset release; one frame = 64 edges
  initial forever begin
    int presc, idx, v;
    exp_t e;
    @(posedge Clk or negedge Reset);
    if (!Reset) begin
      s = 0; d1 = 0; d2 = 0; c1 = 0; c2 = 0;
      q.delete();
    end else begin
      presc = s % 16;
      idx = (s / 16) % 4;
      v = (idx < 2) ? d1 : d2;
      if (Blank || presc < 2) e = '{8'hFF, 8'hFF, 4'hF};
      else e = '{exp_seg(v, idx, 1'b1), exp_seg(v, idx, 1'b0), 4'(~(1 << idx))};
      q.push_back(e);
      if (presc == 15 && idx == 2) begin
        c1 = (Cnt1 > 99) ? 99 : int'(Cnt1);
        c2 = (Cnt2 > 99) ? 99 : int'(Cnt2);
      end
      if (presc == 15 && idx == 3) begin
        d1 = c1;
        d2 = c2;
      end
      s++;
    end
  end

  // Monitor: the pins present a new value every cycle
  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (!Reset) begin
      check("reset_lz", {seg_a, sl_a}, {8'hFF, 4'hF});
      check("reset_nz", {seg_b, sl_b}, {8'hFF, 4'hF});
    end else if (q.size() > 0) begin
      e = q.pop_front();
      check("scan_lz", {seg_a, sl_a}, {e.seg_lz, e.sl});
      check("scan_nz", {seg_b, sl_b}, {e.seg_nz, e.sl});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    cycles(3);
    Reset = 1'b1;
    cycles(64);
    Cnt1 = 7'd25; Cnt2 = 7'd7;
    cycles(192);
    Cnt1 = 7'd120; Cnt2 = 7'd0;
    cycles(192);
    Cnt1 = 7'd25; Cnt2 = 7'd7;
    cycles(148);
    Cnt1 = 7'd18;
    cycles(200);
    cycles(7);
    Blank = 1'b1;
    cycles(5);
    Blank = 1'b0;
    cycles(80);
    for (int i = 0; i < 300; i++) begin
      cycles($urandom_range(1, 40));
      Cnt1 = 7'($urandom_range(0, 127));
      Cnt2 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) begin
        Blank = 1'b1;
        cycles($urandom_range(1, 6));
        Blank = 1'b0;
      end
    end
    Cnt1 = 7'd34; Cnt2 = 7'd57;
    cycles(192);
    for (int i = 0; i < 100 && !((s / 16) % 4 == 2 && s % 16 == 6); i++) @(negedge Clk);
    #20 Reset = 1'b0;
    #1;
    check("async_lz", {seg_a, sl_a}, {8'hFF, 4'hF});
    check("async_nz", {seg_b, sl_b}, {8'hFF, 4'hF});
    cycles(3);
    Reset = 1'b1;
    cycles(192);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
